// File: rtl/reg_dbg_pkg.sv
// Shared types and default sizes for the debug register-file initiator.
package reg_dbg_pkg;

  localparam int NREGS = 32;
  localparam int XLEN  = 32;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    DUMP,
    LOAD,
    DONE
  } state_t;

  typedef enum logic {
    MODE_DUMP,
    MODE_LOAD
  } mode_t;

endpackage

// File: rtl/reg_dbg_ctrl.sv
// Debug initiator: halts the core, then streams the register file out (dump)
// or writes 32 streamed words into it (load).
module reg_dbg_ctrl #(
  parameter int NREGS = reg_dbg_pkg::NREGS,
  parameter int XLEN  = reg_dbg_pkg::XLEN,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_dump,
  input  logic            start_load,
  output logic            busy,
  output logic            done,
  output logic            core_halt,
  output logic [AW-1:0]   rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            rf_wr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [AW-1:0]   out_idx,
  output logic            out_last,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_data
);

  import reg_dbg_pkg::*;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t        state, state_next;
  mode_t         mode, mode_next;
  logic [AW-1:0] idx, idx_next;
  logic          at_last;

  assign at_last = (idx == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mode  <= MODE_DUMP;
      idx   <= '0;
    end else begin
      state <= state_next;
      mode  <= mode_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    mode_next  = mode;
    idx_next   = idx;
    busy       = 1'b0;
    done       = 1'b0;
    core_halt  = 1'b0;
    rf_raddr   = '0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    rf_wr      = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_idx    = '0;
    out_last   = 1'b0;
    in_ready   = 1'b0;

    unique case (state)
      IDLE: begin
        // Dump takes priority when both requests arrive together.
        if (start_dump) begin
          mode_next  = MODE_DUMP;
          idx_next   = '0;
          state_next = HALT;
        end else if (start_load) begin
          mode_next  = MODE_LOAD;
          idx_next   = '0;
          state_next = HALT;
        end
      end

      // Drain cycle: a core write already in flight lands at this negedge.
      HALT: begin
        busy       = 1'b1;
        core_halt  = 1'b1;
        state_next = (mode == MODE_LOAD) ? LOAD : DUMP;
      end

      DUMP: begin
        busy      = 1'b1;
        core_halt = 1'b1;
        rf_raddr  = idx;
        out_valid = 1'b1;
        out_data  = rf_rdata;
        out_idx   = idx;
        out_last  = at_last;
        if (out_ready) begin
          if (at_last) state_next = DONE;
          else         idx_next   = idx + 1'b1;
        end
      end

      LOAD: begin
        busy      = 1'b1;
        core_halt = 1'b1;
        in_ready  = 1'b1;
        rf_waddr  = idx;
        rf_wdata  = in_data;
        // Word for x0 is consumed but never written.
        rf_wr     = in_valid && (idx != '0);
        if (in_valid) begin
          if (at_last) state_next = DONE;
          else         idx_next   = idx + 1'b1;
        end
      end

      DONE: begin
        busy       = 1'b1;
        core_halt  = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_dbg_ctrl.sv
// Bench for reg_dbg_ctrl: register file + core/debug port mux harness,
// scoreboard of expected dump beats built from a bench-side register model.
module tb_reg_dbg_ctrl;

  localparam int NREGS = 32;
  localparam int XLEN  = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            start_dump, start_load;
  logic            busy, done, core_halt;
  logic [AW-1:0]   rf_raddr, rf_waddr;
  logic [XLEN-1:0] rf_rdata, rf_wdata;
  logic            rf_wr;
  logic            out_valid, out_ready, out_last;
  logic [XLEN-1:0] out_data;
  logic [AW-1:0]   out_idx;
  logic            in_valid, in_ready;
  logic [XLEN-1:0] in_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_dbg_ctrl #(.NREGS(NREGS), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start_dump(start_dump), .start_load(start_load),
    .busy(busy), .done(done), .core_halt(core_halt),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_wr(rf_wr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
  );

  // Register file harness: combinational read, negedge write, core write-back stage.
  logic [XLEN-1:0] rf [NREGS];
  logic [XLEN-1:0] exp_rf [NREGS];
  logic            rf_init;
  logic            core_we, core_wb_valid;
  logic [AW-1:0]   core_waddr, core_wb_addr;
  logic [XLEN-1:0] core_wdata, core_wb_data;
  logic [AW-1:0]   rd_addr;

  assign rd_addr  = core_halt ? rf_raddr : '0;
  assign rf_rdata = rf[rd_addr];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_wb_valid <= 1'b0;
      core_wb_addr  <= '0;
      core_wb_data  <= '0;
    end else begin
      core_wb_valid <= core_we;
      core_wb_addr  <= core_waddr;
      core_wb_data  <= core_wdata;
    end
  end

  always @(negedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= 32'(10 * i);
    end else if (rf_wr) begin
      rf[rf_waddr] <= rf_wdata;
    end else if (core_wb_valid) begin
      rf[core_wb_addr] <= core_wb_data;
    end
  end

  logic [85:0] all_out;
  assign all_out = {busy, done, core_halt, rf_wr, out_valid, out_last, in_ready,
                    rf_raddr, rf_waddr, out_idx, rf_wdata, out_data};

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [AW-1:0]   idx;
  } beat_t;
  beat_t sb[$];

  task automatic init_rf();
    rf_init = 1'b1;
    @(negedge clk);
    #1;
    rf_init = 1'b0;
    for (int i = 0; i < NREGS; i++) exp_rf[i] = 32'(10 * i);
  endtask

  // pat 0: always ready; pat 1: ready 1,0,0 repeating.
  task automatic do_dump(input string name, input int pat, input bit with_load,
                         input int load_pulse_at);
    int    busy_cnt = 0, last_hs = -10, first_valid = -1, done_cnt = 0, wr_seen = 0;
    bit    hold = 0, finished = 0;
    beat_t b, held;
    sb.delete();
    for (int i = 0; i < NREGS; i++) begin
      b.data = exp_rf[i];
      b.idx  = AW'(i);
      sb.push_back(b);
    end
    start_dump = 1'b1;
    start_load = with_load;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      start_dump = 1'b0;
      start_load = (c == load_pulse_at);
      core_we    = 1'b0;
      out_ready  = (pat == 0) ? 1'b1 : (c % 3 == 0);
      #3;
      if (busy) busy_cnt++;
      if (rf_wr) wr_seen++;
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held.data || out_idx !== held.idx) begin
          failures++;
          $display("FAIL %s stall_hold: got valid=%b data=%h idx=%0d, need data=%h idx=%0d",
                   name, out_valid, out_data, out_idx, held.data, held.idx);
        end
      end
      hold = 1'b0;
      if (out_valid && first_valid < 0) first_valid = c;
      if (out_valid && !out_ready) begin
        hold      = 1'b1;
        held.data = out_data;
        held.idx  = out_idx;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL %s extra_beat: got idx=%0d data=%h, need no beat", name, out_idx, out_data);
        end else begin
          b = sb.pop_front();
          if (out_data !== b.data || out_idx !== b.idx || out_last !== (b.idx == AW'(NREGS - 1))) begin
            failures++;
            $display("FAIL %s beat: got data=%h idx=%0d last=%b, need data=%h idx=%0d last=%b",
                     name, out_data, out_idx, out_last, b.data, b.idx, (b.idx == AW'(NREGS - 1)));
          end
        end
        last_hs = c;
      end
      if (done) begin
        done_cnt++;
        checks++;
        if (c != last_hs + 1) begin
          failures++;
          $display("FAIL %s done_timing: got cycle %0d, need %0d", name, c, last_hs + 1);
        end
      end
      if (!busy) begin
        finished = 1;
        break;
      end
    end
    out_ready = 1'b0;
    start_load = 1'b0;
    checks++;
    if (!finished || sb.size() != 0) begin
      failures++;
      $display("FAIL %s completion: got finished=%0d beats_left=%0d, need 1 and 0",
               name, finished, sb.size());
    end
    checks++;
    if (first_valid != 1) begin
      failures++;
      $display("FAIL %s first_valid_latency: got cycle %0d, need 1", name, first_valid);
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL %s done_count: got %0d, need 1", name, done_cnt);
    end
    checks++;
    if (wr_seen != 0) begin
      failures++;
      $display("FAIL %s rf_wr_in_dump: got %0d writes, need 0", name, wr_seen);
    end
    if (pat == 0) begin
      checks++;
      if (busy_cnt != 34) begin
        failures++;
        $display("FAIL %s busy_cycles: got %0d, need 34", name, busy_cnt);
      end
    end
  endtask

  // abort_at < 0: full load; otherwise reset asserts right after word abort_at is taken.
  task automatic do_load(input string name, input int abort_at);
    int j = 0, done_cnt = 0;
    bit finished = 0;
    start_load = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      start_load = 1'b0;
      if (abort_at >= 0 && j == abort_at + 1) begin
        in_valid = 1'b1;
        in_data  = 32'h A000_0000 + 32'(j);
        reset    = 1'b1;
        #1;
        checks++;
        if (all_out !== '0) begin
          failures++;
          $display("FAIL %s reset_abort_outputs: got %h, need 0", name, all_out);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rf[j] !== 32'(10 * j)) begin
          failures++;
          $display("FAIL %s no_write_after_reset: got x%0d=%h, need %h", name, j, rf[j], 32'(10 * j));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #4;
        reset = 1'b0;
        return;
      end
      in_valid = (c % 4 != 2);
      in_data  = 32'h A000_0000 + 32'(j);
      #3;
      if (in_ready) begin
        checks++;
        if (rf_waddr !== AW'(j) || rf_wr !== (in_valid && j != 0) ||
            (rf_wr && rf_wdata !== in_data)) begin
          failures++;
          $display("FAIL %s load_port: got waddr=%0d wr=%b wdata=%h, need waddr=%0d wr=%b wdata=%h",
                   name, rf_waddr, rf_wr, rf_wdata, j, (in_valid && j != 0), in_data);
        end
        if (in_valid) begin
          if (j != 0) exp_rf[j] = in_data;
          j++;
        end
      end
      if (done) begin
        done_cnt++;
        checks++;
        if (j != NREGS) begin
          failures++;
          $display("FAIL %s done_early: got %0d words, need %0d", name, j, NREGS);
        end
      end
      if (!busy) begin
        finished = 1;
        break;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (!finished || j != NREGS || done_cnt != 1) begin
      failures++;
      $display("FAIL %s load_complete: got finished=%0d words=%0d done=%0d, need 1 %0d 1",
               name, finished, j, done_cnt, NREGS);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_dump = 1'b1;
    init_rf();
    @(posedge clk);
    #4;
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h, need 0", all_out);
    end
    start_dump = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #4;
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL idle_outputs: got %h, need 0", all_out);
    end
  endtask

  task automatic test_dump_basic();
    do_dump("dump_basic", 0, 1'b0, -1);
  endtask

  task automatic test_dump_stall();
    do_dump("dump_stall", 1, 1'b0, -1);
  endtask

  task automatic test_load();
    do_load("load", -1);
    do_dump("dump_after_load", 0, 1'b0, -1);
  endtask

  task automatic test_both_start();
    do_dump("both_start", 0, 1'b1, 10);
    @(posedge clk);
    #4;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL ignored_start_load: got busy=%b, need 0", busy);
    end
  endtask

  task automatic test_reset_mid_load();
    init_rf();
    do_load("reset_mid_load", 10);
    do_dump("dump_after_abort", 0, 1'b0, -1);
  endtask

  task automatic test_core_write_drain();
    init_rf();
    core_we    = 1'b1;
    core_waddr = 5'd5;
    core_wdata = 32'h0000_1234;
    exp_rf[5]  = 32'h0000_1234;
    do_dump("core_drain", 0, 1'b0, -1);
  endtask

  initial begin
    reset = 1'b1;
    start_dump = 1'b0;
    start_load = 1'b0;
    out_ready  = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    rf_init    = 1'b0;
    core_we    = 1'b0;
    core_waddr = '0;
    core_wdata = '0;
    test_reset();
    test_dump_basic();
    test_dump_stall();
    test_load();
    test_both_start();
    test_reset_mid_load();
    test_core_write_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_dbg_ctrl.md
Name: reg_dbg_ctrl

Overview:
Debug-side initiator for the 32x32 register file. On request it halts the core and does one of two things:
- Dump: reads all registers in order and streams them out over a valid/ready port.
- Load: accepts 32 words over a valid/ready input port and writes them into the register file.

It drives the register file's raddr/waddr/wdata/reg_wr port (muxed in place of the datapath while core_halt=1) and consumes its combinational read data.

Parameters:
NREGS, 32, number of architectural registers to dump/load
XLEN, 32, data width
AW, 5, register index width, equals $clog2(NREGS)

Ports:
clk  in  1  clock; all controller state changes on posedge
reset  in  1  reset, asynchronous, active-high
start_dump  in  1  request a dump; sampled in IDLE only
start_load  in  1  request a load; sampled in IDLE only
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when an operation completes
core_halt  out  1  core must not write the register file; select debug port
rf_raddr  out  AW  register file read address
rf_rdata  in  XLEN  register file read data, combinational from rf_raddr
rf_waddr  out  AW  register file write address
rf_wdata  out  XLEN  register file write data
rf_wr  out  1  register file write enable
out_valid  out  1  dump stream data valid
out_ready  in  1  dump stream sink ready
out_data  out  XLEN  dump word, equals rf_rdata
out_idx  out  AW  register index of out_data
out_last  out  1  high with the word for index NREGS-1
in_valid  in  1  load stream data valid
in_ready  out  1  load stream accept
in_data  in  XLEN  load word

Behaviour:
- States: IDLE, HALT, DUMP, LOAD, DONE. Index counter idx is AW bits wide.
- Reset, asynchronous: state=IDLE, idx=0, latched mode=dump. Every output is 0 while in reset and in IDLE (busy, done, core_halt, rf_wr, out_valid, in_ready, addresses, data).
- IDLE:
  - start_dump → HALT with mode=dump.
  - start_load → HALT with mode=load.
  - Both high: dump wins. idx cleared to 0.
- HALT: one drain cycle, so any in-flight core write lands at this cycle's negedge before the debug port takes over. Then go to DUMP or LOAD according to mode.
- core_halt and busy: high in HALT, DUMP, LOAD and DONE.
- DUMP:
  - rf_raddr=idx, out_valid=1, out_data=rf_rdata, out_idx=idx, out_last=(idx==NREGS-1).
  - On out_valid&&out_ready: if idx==NREGS-1, go to DONE; otherwise idx+1.
  - Without ready, the word holds stable; the core is halted, so rf_rdata cannot change.
  - rf_wr=0 throughout.
- LOAD:
  - in_ready=1, rf_waddr=idx, rf_wdata=in_data.
  - rf_wr=in_valid && (idx!=0). Combinational, so the register file captures at that cycle's negedge.
  - The word for idx 0 is accepted and discarded; x0 stays 0.
  - On handshake: if idx==NREGS-1, go to DONE; otherwise idx+1.
- DONE: done=1 for exactly one cycle, then IDLE. core_halt drops on entry to IDLE.
- Start inputs are ignored in every state except IDLE; no queuing.
- Reset mid-operation: abort immediately, with no partial-word write after reset asserts. Registers already loaded keep their new values.
- Latency:
  - Start sampled at edge N; HALT in cycle N+1; first out_valid or in_ready in cycle N+2.
  - Full dump or load with no stalls: 1+32+1 = 34 busy cycles.
- idx never wraps. The terminal transition happens at NREGS-1.

Decomposition:
- Package reg_dbg_pkg:
  - state enum (IDLE, HALT, DUMP, LOAD, DONE)
  - mode enum (MODE_DUMP, MODE_LOAD)
  - NREGS and XLEN localparams
- No sub-module; the FSM and idx counter form a single block.
- The existing register file plus a 2:1 port mux controlled by core_halt is the bench DUT harness.

Test Plan:
1. Reset the register file (xi=10*i), start_dump, out_ready=1 → 32 beats: out_data 0,10,20,…,310 with out_idx 0..31; out_last only on beat 31; done on the cycle after beat 31; busy high for 34 cycles.
2. Dump with out_ready toggled 1,0,0,1,… → no word skipped or duplicated; out_data/out_idx stable while out_valid&&!out_ready; sequence still 0..310.
3. start_load, feed 0xA000_0000+i for i=0..31 with in_valid gaps, then dump → x0=0, xi=0xA000_0000+i for i=1..31; rf_wr never high when idx=0.
4. start_dump and start_load asserted together → dump performed; a start_load pulse during the dump is ignored, and busy falls after 34 cycles.
5. Assert reset mid-load after word 10 → state IDLE and all outputs 0 immediately; x1..x10 hold the loaded values, x11 unchanged (110).
6. Core datapath writes x5=0x1234 in the cycle start_dump is sampled → write completes in HALT; the dump reports x5=0x1234.
